fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/rr_pick.sv | 47 ++++
 rtl/fifo_wr_arb.sv | 142 ++++++++++++++
 tb/tb_fifo_wr_arb.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the FIFO family: the write-arbiter state encoding
//   and a constant-evaluable ceil(log2) used to size indices and counters.
// ---------------------------------------------------------------------------
package fifo_pkg;

    // Write-arbiter FSM states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // ceil(log2(value)); returns 0 for value <= 1. Usable in parameter context.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage : fifo_pkg

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Purely combinational round-robin priority search. Returns the first set
//   bit of req, searching upward from ptr and wrapping N_REQ-1 -> 0.
//
// Ports
//   req          in   N_REQ  request vector
//   ptr          in   IDX_W  search start index (0..N_REQ-1)
//   pick_onehot  out  N_REQ  one-hot winner, all zero when req is zero
//   pick_idx     out  IDX_W  binary index of the winner, 0 when req is zero
// ---------------------------------------------------------------------------
module rr_pick
    import fifo_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick_onehot,
    output logic [IDX_W-1:0] pick_idx
);

    logic found;
    int   cand;

    always_comb begin
        // NOTE: every output and temporary gets a default before the loop so
        // no path leaves a value unassigned, which would infer a latch.
        pick_onehot = '0;
        pick_idx    = '0;
        found       = 1'b0;
        cand        = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!found && req[cand]) begin
                found             = 1'b1;
                pick_onehot[cand] = 1'b1;
                pick_idx          = IDX_W'(cand);
            end
        end
    end

endmodule : rr_pick

// File: rtl/fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// fifo_wr_arb
//   Round-robin arbiter that lets N_REQ requesters take turns writing packet
//   bursts into one downstream synchronous FIFO. A grant is held until the
//   owner's last beat, MAX_BURST beats, or IDLE_TO owner-idle cycles.
//
// Ports
//   clk        in   1                 clock, rising edge
//   rst_n      in   1                 asynchronous active-low reset
//   req_valid  in   N_REQ             per-requester beat valid
//   req_last   in   N_REQ             per-requester last beat of packet
//   req_data   in   N_REQ*DATA_WIDTH  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  out  N_REQ             per-requester accept (combinational)
//   fifo_full  in   1                 downstream FIFO full
//   fifo_wr    out  1                 FIFO write strobe
//   fifo_din   out  DATA_WIDTH        FIFO write data, zero when not writing
//   grant      out  N_REQ             one-hot owner, zero when idle
//   busy       out  1                 a grant is held
// ---------------------------------------------------------------------------
module fifo_wr_arb
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 4,
    parameter int MAX_BURST  = 16,
    parameter int IDLE_TO    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_last,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_wr,
    output logic [DATA_WIDTH-1:0]       fifo_din,
    output logic [N_REQ-1:0]            grant,
    output logic                        busy
);

    localparam int IDX_W  = clog2(N_REQ);
    localparam int BEAT_W = clog2(MAX_BURST + 1);
    localparam int IDLE_W = clog2(IDLE_TO + 1);

    arb_state_t              state;
    logic [IDX_W-1:0]        owner;
    logic [IDX_W-1:0]        rr_ptr;
    logic [BEAT_W-1:0]       beat_cnt;
    logic [IDLE_W-1:0]       idle_cnt;

    logic [N_REQ-1:0]        pick_onehot;
    logic [IDX_W-1:0]        pick_idx;

    logic [N_REQ-1:0]        owner_onehot;
    logic                    owner_valid;
    logic                    owner_last;
    logic [DATA_WIDTH-1:0]   owner_data;
    logic [BEAT_W-1:0]       beat_nxt;
    logic [IDLE_W-1:0]       idle_nxt;
    logic [IDX_W-1:0]        ptr_after_owner;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req         (req_valid),
        .ptr         (rr_ptr),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx)
    );

    // Owner-side view of the request bundle; everything downstream only ever
    // looks at the owner, so non-owner valid/last/data cannot leak through.
    always_comb begin
        owner_onehot        = '0;
        owner_onehot[owner] = 1'b1;
        owner_valid         = req_valid[owner];
        owner_last          = req_last[owner];
        owner_data          = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];

        req_ready = (state == ST_BURST && !fifo_full) ? owner_onehot : '0;
        fifo_wr   = owner_valid & req_ready[owner];
        fifo_din  = fifo_wr ? owner_data : '0;

        beat_nxt        = beat_cnt + BEAT_W'(1);
        idle_nxt        = idle_cnt + IDLE_W'(1);
        ptr_after_owner = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
    end

    // The release paths are mutually exclusive (accepted beat vs idle cycle),
    // so a last beat landing on MAX_BURST still releases exactly once.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state    <= ST_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
            grant    <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        state    <= ST_BURST;
                        owner    <= pick_idx;
                        grant    <= pick_onehot;
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                    end
                end
                ST_BURST: begin
                    // A full FIFO freezes grant, beat count and idle count.
                    if (!fifo_full) begin
                        if (owner_valid) begin
                            beat_cnt <= beat_nxt;
                            idle_cnt <= '0;
                            if (owner_last || beat_nxt == BEAT_W'(MAX_BURST)) begin
                                state  <= ST_IDLE;
                                grant  <= '0;
                                busy   <= 1'b0;
                                rr_ptr <= ptr_after_owner;
                            end
                        end else begin
                            idle_cnt <= idle_nxt;
                            if (idle_nxt == IDLE_W'(IDLE_TO)) begin
                                state  <= ST_IDLE;
                                grant  <= '0;
                                busy   <= 1'b0;
                                rr_ptr <= ptr_after_owner;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule : fifo_wr_arb

// File: tb/tb_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arb
//   Directed bench for fifo_wr_arb. Per-requester beat queues feed a small
//   requester driver; expected FIFO writes go into a scoreboard queue that a
//   separate monitor drains whenever fifo_wr is seen. The main process also
//   checks the per-cycle grant trace against hand-computed tables.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arb;

    localparam int DW = 8;
    localparam int NR = 4;

    typedef struct packed {
        logic          bubble;  // one cycle of valid low, not a beat
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct packed {
        logic [NR-1:0] grant;
        logic [DW-1:0] data;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0]        req_last;
    logic [NR*DW-1:0]     req_data;
    logic [NR-1:0]        req_ready;
    logic                 fifo_full;
    logic                 fifo_wr;
    logic [DW-1:0]        fifo_din;
    logic [NR-1:0]        grant;
    logic                 busy;

    beat_t                src_q [NR][$];
    logic  [NR-1:0]       shown_bubble;
    logic  [NR-1:0]       acc;
    exp_t                 exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    fifo_wr_arb #(
        .DATA_WIDTH (DW),
        .N_REQ      (NR),
        .MAX_BURST  (16),
        .IDLE_TO    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_din  (fifo_din),
        .grant     (grant),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_beats(input int r, input logic [DW-1:0] base, input int n, input bit last_at_end);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.bubble = 1'b0;
            b.last   = last_at_end && (i == n - 1);
            b.data   = base + DW'(i);
            src_q[r].push_back(b);
        end
    endtask

    task automatic push_bubbles(input int r, input int n);
        beat_t b;
        b = '{bubble: 1'b1, last: 1'b0, data: '0};
        for (int i = 0; i < n; i++) src_q[r].push_back(b);
    endtask

    task automatic expect_writes(input logic [NR-1:0] g, input logic [DW-1:0] base, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.grant = g;
            e.data  = base + DW'(i);
            exp_q.push_back(e);
        end
    endtask

    // One cycle of the grant trace, sampled on the falling edge.
    task automatic chk_cycle(input string tag, input int k, input logic [NR-1:0] exp_g);
        @(negedge clk);
        check($sformatf("%s grant k=%0d", tag, k), 32'(grant), 32'(exp_g));
        check($sformatf("%s busy k=%0d", tag, k), 32'(busy), 32'(exp_g != '0));
    endtask

    // Requester driver: sample acceptance on the falling edge, advance the
    // per-requester queues just after the rising edge.
    initial begin
        req_valid    = '0;
        req_last     = '0;
        req_data     = '0;
        shown_bubble = '0;
        acc          = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (src_q[i].size() > 0) begin
                    if (shown_bubble[i] || acc[i]) void'(src_q[i].pop_front());
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (src_q[i].size() > 0) begin
                    req_valid[i]           = ~src_q[i][0].bubble;
                    req_last[i]            = src_q[i][0].last;
                    req_data[i*DW +: DW]   = src_q[i][0].data;
                    shown_bubble[i]        = src_q[i][0].bubble;
                end else begin
                    req_valid[i]           = 1'b0;
                    req_last[i]            = 1'b0;
                    shown_bubble[i]        = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (fifo_wr === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL write_unexpected: got din 0x%0h grant 0x%0h, none expected (t=%0t)",
                             fifo_din, grant, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("write_data", 32'(fifo_din), 32'(e.data));
                    check("write_grant", 32'(grant), 32'(e.grant));
                    check("write_ready", 32'(req_ready), 32'(e.grant));
                end
            end else begin
                check("din_when_idle", 32'(fifo_din), 32'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NR-1:0] g;
        rst_n     = 1'b0;
        fifo_full = 1'b0;

        // Reset and idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst grant", 32'(grant), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        check("rst ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle grant", 32'(grant), 32'h0);
        check("idle busy", 32'(busy), 32'h0);
        check("idle wr", 32'(fifo_wr), 32'h0);
        check("idle din", 32'(fifo_din), 32'h0);
        check("idle ready", 32'(req_ready), 32'h0);

        // Requesters 0 and 2, 3-beat packets each.
        push_beats(0, 8'h10, 3, 1'b1);
        push_beats(2, 8'h20, 3, 1'b1);
        expect_writes(4'b0001, 8'h10, 3);
        expect_writes(4'b0100, 8'h20, 3);
        for (int k = 0; k < 9; k++) begin
            g = (k >= 1 && k <= 3) ? 4'b0001 : (k >= 5 && k <= 7) ? 4'b0100 : 4'b0000;
            chk_cycle("two_pkts", k, g);
        end

        // Requester 1, 20 beats, no last: MAX_BURST release, regrant, idle timeout.
        push_beats(1, 8'h40, 20, 1'b0);
        expect_writes(4'b0010, 8'h40, 20);
        for (int k = 0; k < 32; k++) begin
            g = (k == 0 || k == 17 || k >= 30) ? 4'b0000 : 4'b0010;
            chk_cycle("max_burst", k, g);
        end

        // Requester 3, 6 beats, FIFO full for 5 cycles mid-packet.
        push_beats(3, 8'h60, 6, 1'b1);
        expect_writes(4'b1000, 8'h60, 6);
        for (int k = 0; k < 13; k++) begin
            if (k == 3) begin
                @(posedge clk);
                #1 fifo_full = 1'b1;
            end
            if (k == 8) begin
                @(posedge clk);
                #1 fifo_full = 1'b0;
            end
            g = (k >= 1 && k <= 11) ? 4'b1000 : 4'b0000;
            chk_cycle("full_stall", k, g);
            if (k >= 3 && k <= 7) begin
                check($sformatf("stall wr k=%0d", k), 32'(fifo_wr), 32'h0);
                check($sformatf("stall ready k=%0d", k), 32'(req_ready), 32'h0);
            end
        end

        // Owner 0 goes quiet for 8 cycles; pending requester 2 takes over.
        push_beats(0, 8'h70, 2, 1'b0);
        push_bubbles(0, 8);
        push_beats(0, 8'h72, 1, 1'b1);
        push_beats(2, 8'h80, 1, 1'b1);
        expect_writes(4'b0001, 8'h70, 2);
        expect_writes(4'b0100, 8'h80, 1);
        expect_writes(4'b0001, 8'h72, 1);
        for (int k = 0; k < 16; k++) begin
            g = (k >= 1 && k <= 10) ? 4'b0001 : (k == 12) ? 4'b0100 :
                (k == 14) ? 4'b0001 : 4'b0000;
            chk_cycle("idle_to", k, g);
        end

        // Reset mid-burst abandons the packet.
        push_beats(1, 8'h90, 3, 1'b1);
        expect_writes(4'b0010, 8'h90, 1);
        chk_cycle("mid_rst", 0, 4'b0000);
        chk_cycle("mid_rst", 1, 4'b0010);
        @(posedge clk);
        #2 rst_n = 1'b0;
        src_q[1].delete();
        @(negedge clk);
        check("mid_rst grant", 32'(grant), 32'h0);
        check("mid_rst busy", 32'(busy), 32'h0);
        check("mid_rst wr", 32'(fifo_wr), 32'h0);
        check("mid_rst ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // All four requesters continuously valid with 1-beat packets.
        for (int r = 0; r < NR; r++) begin
            push_beats(r, 8'hA0 + DW'(r), 1, 1'b1);
            push_beats(r, 8'hB0 + DW'(r), 1, 1'b1);
        end
        for (int r = 0; r < NR; r++) expect_writes(4'b0001 << r, 8'hA0 + DW'(r), 1);
        for (int r = 0; r < NR; r++) expect_writes(4'b0001 << r, 8'hB0 + DW'(r), 1);
        for (int k = 0; k < 17; k++) begin
            g = (k % 2 == 1) ? (4'b0001 << (((k - 1) / 2) % NR)) : 4'b0000;
            chk_cycle("rr_order", k, g);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fifo_wr_arb
